cpu_spr_dma: RTL

Sprite DMA engine that responds to CPU bus writes at $4014. It then takes ownership of the CPU bus by asserting o_PAUSE, which connects to the CPU's i_PAUSE. While paused, the CPU holds all state and forces its R_WN high. The engine copies 256 bytes from page {data,8'h00} to OAM_DATA at $2004, using alternating read and write cycles with NES-accurate 513/514-cycle alignment.

---
 rtl/cpu_bus_pkg.sv | 15 +
 rtl/cpu_spr_dma_if.sv | 26 ++
 rtl/cpu_spr_dma.sv | 87 ++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared CPU-bus constants and the sprite DMA state encoding.
package cpu_bus_pkg;

    localparam logic [15:0] REG_ADDR      = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/cpu_spr_dma_if.sv
// CPU snoop inputs, bus read data and DMA master outputs of the sprite DMA.
interface cpu_spr_dma_if;

    logic [15:0] i_CPU_ADDR;
    logic [7:0]  i_CPU_DATA;
    logic        i_CPU_R_WN;
    logic [7:0]  i_BUS_DATA;
    logic        o_PAUSE;
    logic [15:0] o_DMA_ADDR;
    logic [7:0]  o_DMA_DATA;
    logic        o_DMA_R_WN;
    logic        o_BUSY;

    // Console side: CPU bus and memory system.
    modport master (
        output i_CPU_ADDR, i_CPU_DATA, i_CPU_R_WN, i_BUS_DATA,
        input  o_PAUSE, o_DMA_ADDR, o_DMA_DATA, o_DMA_R_WN, o_BUSY
    );

    // DMA engine side.
    modport slave (
        input  i_CPU_ADDR, i_CPU_DATA, i_CPU_R_WN, i_BUS_DATA,
        output o_PAUSE, o_DMA_ADDR, o_DMA_DATA, o_DMA_R_WN, o_BUSY
    );

endinterface

// File: rtl/cpu_spr_dma.sv
// Sprite DMA: a write to $4014 pauses the CPU and copies page {data,00} to $2004.
module cpu_spr_dma
    import cpu_bus_pkg::*;
(
    input  logic          i_CLK,
    input  logic          i_RST_N,
    cpu_spr_dma_if.slave  bus
);

    dma_state_e  state_q, state_d;
    logic [7:0]  page_q,  page_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [7:0]  data_q,  data_d;
    logic        parity_q, parity_d;

    logic [15:0] dma_addr_c;
    logic [7:0]  dma_data_c;
    logic        dma_r_wn_c;

    // State, page, byte counter, read latch and free-running parity.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q  <= ST_IDLE;
            page_q   <= 8'h00;
            cnt_q    <= 8'h00;
            data_q   <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            parity_q <= parity_d;
        end
    end

    // Next state: trigger, one halt cycle, optional align, then read/write pairs.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        parity_d = ~parity_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!bus.i_CPU_R_WN && (bus.i_CPU_ADDR == REG_ADDR)) begin
                    page_d  = bus.i_CPU_DATA;
                    cnt_d   = 8'h00;
                    state_d = ST_HALT;
                end
            end
            // Odd halt cycle means the next cycle is even and can start reading.
            ST_HALT:  state_d = parity_q ? ST_READ : ST_ALIGN;
            ST_ALIGN: state_d = ST_READ;
            ST_READ: begin
                data_d  = bus.i_BUS_DATA;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = (cnt_q == 8'hFF) ? ST_IDLE : ST_READ;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus drive decoded from state; source address wraps within the page.
    always_comb begin
        dma_addr_c = 16'h0000;
        dma_data_c = 8'h00;
        dma_r_wn_c = 1'b1;
        if (state_q == ST_READ) begin
            dma_addr_c = {page_q, cnt_q};
        end else if (state_q == ST_WRITE) begin
            dma_addr_c = OAM_DATA_ADDR;
            dma_data_c = data_q;
            dma_r_wn_c = 1'b0;
        end
    end

    assign bus.o_PAUSE    = (state_q != ST_IDLE);
    assign bus.o_BUSY     = (state_q != ST_IDLE);
    assign bus.o_DMA_ADDR = dma_addr_c;
    assign bus.o_DMA_DATA = dma_data_c;
    assign bus.o_DMA_R_WN = dma_r_wn_c;

endmodule
